// File: rtl/mul_pkg.sv
// Shared multiplier/divider writeback types: widths, queue tag/entry layouts and funct3 encodings.
package mul_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned RD_W = 5;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic            hi;
        logic            w;
    } mul_tag_t;

    typedef struct packed {
        mul_tag_t        tag;
        logic            done;
        logic [XLEN-1:0] data;
    } mul_entry_t;

    // RV64M funct3 values seen by upstream issue logic
    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011
    } mul_funct3_e;

    function automatic logic f3_is_hi(mul_funct3_e f3);
        return f3 != F3_MUL;
    endfunction

    function automatic logic f3_is_signed(mul_funct3_e f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU);
    endfunction

endpackage

// File: rtl/mul_wb_queue_if.sv
// Issue, multiplier-result and writeback signals of the multiplier writeback queue.
interface mul_wb_queue_if;
    import mul_pkg::*;

    logic                issue_fire;
    logic [RD_W-1:0]     issue_rd;
    logic                issue_hi;
    logic                issue_w;
    logic                issue_allow;
    logic                mul_out_valid;
    logic [XLEN-1:0]     mul_result_hi;
    logic [XLEN-1:0]     mul_result_lo;
    logic                flush;
    logic                wb_valid;
    logic                wb_ready;
    logic [RD_W-1:0]     wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                proto_err;

    modport master (
        output issue_fire, issue_rd, issue_hi, issue_w,
        output mul_out_valid, mul_result_hi, mul_result_lo,
        output flush, wb_ready,
        input  issue_allow, wb_valid, wb_rd, wb_data, proto_err
    );

    modport slave (
        input  issue_fire, issue_rd, issue_hi, issue_w,
        input  mul_out_valid, mul_result_hi, mul_result_lo,
        input  flush, wb_ready,
        output issue_allow, wb_valid, wb_rd, wb_data, proto_err
    );

endinterface

// File: rtl/mul_res_fmt.sv
// Selects/extends the 64-bit writeback value from a multiplier (or divider) result pair.
module mul_res_fmt
    import mul_pkg::*;
(
    input  logic            hi_i,
    input  logic            w_i,
    input  logic [XLEN-1:0] result_hi_i,
    input  logic [XLEN-1:0] result_lo_i,
    output logic [XLEN-1:0] data_o
);

    // Word ops win over hi-select
    always_comb begin
        data_o = result_lo_i;
        if (w_i) begin
            data_o = {{(XLEN-32){result_lo_i[31]}}, result_lo_i[31:0]};
        end else if (hi_i) begin
            data_o = result_hi_i;
        end
    end

endmodule

// File: rtl/mul_wb_queue.sv
// In-order tag queue pairing multiplier results with issued ops and holding them for writeback.
module mul_wb_queue
    import mul_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic           clock,
    input  logic           reset,
    mul_wb_queue_if.slave  bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    mul_entry_t       entry_q [DEPTH];
    mul_entry_t       entry_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             proto_err_q, proto_err_d;

    logic             full_c;
    logic             head_done_c;
    logic             pending_c;
    logic             push_c;
    logic             pop_c;
    mul_tag_t         fill_tag_c;
    logic [XLEN-1:0]  fmt_data_c;

    assign full_c      = (count_q == CNT_W'(DEPTH));
    assign head_done_c = (count_q != '0) && entry_q[head_q].done;
    // fill==tail is ambiguous when full: then the head entry itself may still be waiting
    assign pending_c   = (fill_q != tail_q) || (full_c && !entry_q[fill_q].done);
    assign push_c      = bus.issue_fire && !full_c;
    assign pop_c       = head_done_c && bus.wb_ready;
    assign fill_tag_c  = entry_q[fill_q].tag;

    mul_res_fmt u_fmt (
        .hi_i        (fill_tag_c.hi),
        .w_i         (fill_tag_c.w),
        .result_hi_i (bus.mul_result_hi),
        .result_lo_i (bus.mul_result_lo),
        .data_o      (fmt_data_c)
    );

    // Next-state: flush overrides issue, completion and pop in the same cycle
    always_comb begin
        entry_d     = entry_q;
        head_d      = head_q;
        tail_d      = tail_q;
        fill_d      = fill_q;
        count_d     = count_q;
        proto_err_d = proto_err_q;

        if (bus.flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_d[i].done = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            fill_d  = '0;
            count_d = '0;
        end else begin
            if (push_c) begin
                entry_d[tail_q].tag.rd = bus.issue_rd;
                entry_d[tail_q].tag.hi = bus.issue_hi;
                entry_d[tail_q].tag.w  = bus.issue_w;
                entry_d[tail_q].done   = 1'b0;
                tail_d                 = tail_q + PTR_W'(1);
            end else if (bus.issue_fire) begin
                proto_err_d = 1'b1;
            end

            if (bus.mul_out_valid) begin
                if (pending_c) begin
                    entry_d[fill_q].data = fmt_data_c;
                    entry_d[fill_q].done = 1'b1;
                    fill_d               = fill_q + PTR_W'(1);
                end else begin
                    proto_err_d = 1'b1;
                end
            end

            if (pop_c) begin
                entry_d[head_q].done = 1'b0;
                head_d               = head_q + PTR_W'(1);
            end

            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Head entry is only visible while it is complete
    assign bus.issue_allow = !full_c;
    assign bus.wb_valid    = head_done_c;
    assign bus.wb_rd       = head_done_c ? entry_q[head_q].tag.rd : '0;
    assign bus.wb_data     = head_done_c ? entry_q[head_q].data   : '0;
    assign bus.proto_err   = proto_err_q;

endmodule
